// File: rtl/circ_frame_assembler_pkg.sv
// Shared CIRC frame-assembly constants and types.
package circ_pkg;
    localparam int CIRC_WIDTH    = 8;
    localparam int CIRC_C2_WORDS = 28;

    typedef logic [CIRC_WIDTH-1:0] circ_sym_t;
    typedef circ_sym_t [CIRC_C2_WORDS-1:0] circ_frame_t;

    typedef enum logic {HUNT = 1'b0, FILL = 1'b1} asm_state_t;
endpackage

// File: rtl/circ_frame_assembler.sv
// Serial C1 symbol stream -> parallel double-buffered C2 frame with strobe.
// Define CIRC_ERASURE_EN to carry per-symbol erasure flags alongside the data.
module circ_frame_assembler
    import circ_pkg::*;
#(
    parameter int WIDTH = CIRC_WIDTH,
    parameter int WORDS = CIRC_C2_WORDS,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_sof,
`ifdef CIRC_ERASURE_EN
    input  logic                         in_erase,
    output logic [WORDS-1:0]             erase_q,
    output logic                         erase_any,
`endif
    output logic                         in_rdy,
    output logic [WORDS-1:0][WIDTH-1:0]  q,
    output logic                         frame_stb,
    output logic                         frame_err,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int IDX_W = $clog2(WORDS);

    asm_state_t                      state, nxt_state;
    logic [IDX_W-1:0]                idx, nxt_idx, wr_sel;
    logic [WORDS-2:0][WIDTH-1:0]     shadow;
    logic                            acc, wr_en, complete, err, inc;
`ifdef CIRC_ERASURE_EN
    logic [WORDS-2:0]                erase_shadow;
`endif

    assign acc = in_valid && in_rdy;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        wr_en     = 1'b0;
        wr_sel    = '0;
        complete  = 1'b0;
        err       = 1'b0;
        inc       = 1'b0;
        if (acc) begin
            if (in_sof) begin
                // any SOF restarts at symbol 0; mid-frame it discards the partial
                wr_en     = 1'b1;
                nxt_idx   = IDX_W'(1);
                nxt_state = FILL;
                if (state == FILL && idx != '0) begin
                    err = 1'b1;
                    inc = 1'b1;
                end
            end else if (state == FILL) begin
                if (idx == '0) begin
                    err       = 1'b1;
                    nxt_state = HUNT;
                end else if (idx == IDX_W'(WORDS-1)) begin
                    complete = 1'b1;
                    nxt_idx  = '0;
                end else begin
                    wr_en   = 1'b1;
                    wr_sel  = idx;
                    nxt_idx = idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            shadow    <= '0;
            q         <= '0;
            in_rdy    <= 1'b0;
            frame_stb <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= nxt_state;
            idx       <= nxt_idx;
            in_rdy    <= 1'b1;
            frame_stb <= complete;
            frame_err <= err;
            if (inc && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
            if (wr_en)
                shadow[wr_sel] <= in_data;
            // final symbol bypasses the shadow so Q is ready one cycle later
            if (complete)
                q <= {in_data, shadow};
        end
    end

`ifdef CIRC_ERASURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            erase_shadow <= '0;
            erase_q      <= '0;
            erase_any    <= 1'b0;
        end else begin
            if (wr_en)
                erase_shadow[wr_sel] <= in_erase;
            if (complete) begin
                erase_q   <= {in_erase, erase_shadow};
                erase_any <= in_erase || (|erase_shadow);
            end
        end
    end
`endif
endmodule

// File: tb/tb_circ_frame_assembler.sv
// Randomized self-checking bench for circ_frame_assembler against a queue-based frame model.
module tb_circ_frame_assembler;
    localparam int WIDTH = 8;
    localparam int WORDS = 28;
    localparam int CNT_W = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [WIDTH-1:0]            in_data = '0;
    logic                        in_valid = 1'b0;
    logic                        in_sof = 1'b0;
    logic                        in_rdy;
    logic [WORDS-1:0][WIDTH-1:0] q;
    logic                        frame_stb, frame_err;
    logic [CNT_W-1:0]            drop_cnt;
`ifdef CIRC_ERASURE_EN
    logic                        in_erase = 1'b0;
    logic [WORDS-1:0]            erase_q;
    logic                        erase_any;
`endif

    circ_frame_assembler #(.WIDTH(WIDTH), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
`ifdef CIRC_ERASURE_EN
        .in_erase(in_erase), .erase_q(erase_q), .erase_any(erase_any),
`endif
        .in_rdy(in_rdy), .q(q), .frame_stb(frame_stb), .frame_err(frame_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    // reference model: the frame under construction is simply a queue
    logic [WIDTH-1:0]            mbuf[$];
    bit                          mebuf[$];
    bit                          mhunt = 1'b1;
    bit                          m_rdy = 1'b0, m_stb = 1'b0, m_err = 1'b0, m_eany = 1'b0;
    int                          m_drop = 0;
    logic [WORDS-1:0][WIDTH-1:0] m_q = '0;
    logic [WORDS-1:0]            m_eq = '0;
    int                          nstb = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d, input bit e);
        m_stb = 1'b0;
        m_err = 1'b0;
        if (r) begin
            mbuf.delete(); mebuf.delete();
            mhunt = 1'b1; m_rdy = 1'b0; m_drop = 0;
            m_q = '0; m_eq = '0; m_eany = 1'b0;
            return;
        end
        if (v && m_rdy) begin
            if (s) begin
                if (!mhunt && mbuf.size() != 0) begin
                    m_err = 1'b1;
                    if (m_drop < (1 << CNT_W) - 1) m_drop++;
                end
                mbuf.delete(); mebuf.delete();
                mbuf.push_back(d); mebuf.push_back(e);
                mhunt = 1'b0;
            end else if (!mhunt) begin
                if (mbuf.size() == 0) begin
                    m_err = 1'b1;
                    mhunt = 1'b1;
                end else begin
                    mbuf.push_back(d); mebuf.push_back(e);
                    if (mbuf.size() == WORDS) begin
                        for (int i = 0; i < WORDS; i++) begin
                            m_q[i]  = mbuf[i];
                            m_eq[i] = mebuf[i];
                        end
                        m_eany = |m_eq;
                        m_stb  = 1'b1;
                        mbuf.delete(); mebuf.delete();
                    end
                end
            end
        end
        m_rdy = 1'b1;
    endtask

    task automatic cyc(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d, input bit e);
        rst = r; in_valid = v; in_sof = s; in_data = d;
`ifdef CIRC_ERASURE_EN
        in_erase = e;
`endif
        @(posedge clk);
        model(r, v, s, d, e);
        #1;
        if (frame_stb) nstb++;
        chk("in_rdy", 256'(in_rdy), 256'(m_rdy));
        chk("frame_stb", 256'(frame_stb), 256'(m_stb));
        chk("frame_err", 256'(frame_err), 256'(m_err));
        chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
        chk("q", 256'(q), 256'(m_q));
`ifdef CIRC_ERASURE_EN
        chk("erase_q", 256'(erase_q), 256'(m_eq));
        chk("erase_any", 256'(erase_any), 256'(m_eany));
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, WIDTH'($urandom), 1'($urandom));
    endtask

    // n symbols base+i, SOF on the first if asked; optional random idle gaps
    task automatic send(input int base, input int n, input bit sof, input bit gaps, input int ers);
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) idle();
            cyc(1'b0, 1'b1, sof && i == 0, WIDTH'(base + i),
                (i == ers) || ($urandom_range(0, 31) == 0 && gaps));
        end
    endtask

    initial begin
        int s0;
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        // first cycle out of reset: in_rdy still low, this SOF must be ignored
        cyc(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);

        send(8'h00, WORDS, 1'b1, 1'b0, -1);       // plain frame
        idle();
        s0 = nstb;
        send(8'h10, WORDS, 1'b1, 1'b0, 5);        // back-to-back A, B
        send(8'h80, WORDS, 1'b1, 1'b0, -1);
        idle();
        chk("two_strobes", 256'(nstb - s0), 256'(2));

        send(8'h20, 10, 1'b1, 1'b0, -1);          // interrupted by SOF
        send(8'h40, WORDS, 1'b1, 1'b0, -1);
        idle();

        send(8'h55, 4, 1'b0, 1'b0, -1);           // stray symbols in HUNT
        send(8'h60, WORDS, 1'b1, 1'b0, 5);
        cyc(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);       // sync loss right after a frame
        send(8'h66, 3, 1'b0, 1'b0, -1);
        send(8'h70, WORDS, 1'b1, 1'b1, -1);

        send(8'h90, 15, 1'b1, 1'b0, -1);          // reset mid-frame
        cyc(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h98, 1'b0);
        send(8'hA0, WORDS, 1'b1, 1'b1, -1);

        for (int k = 0; k < 60; k++) begin        // random mix
            case ($urandom_range(0, 5))
                0:       send(int'($urandom), $urandom_range(1, WORDS - 1), 1'b1, 1'b1, -1);
                1:       send(int'($urandom), $urandom_range(1, 3), 1'b0, 1'b1, -1);
                default: send(int'($urandom), WORDS, 1'b1, 1'b1, -1);
            endcase
        end

        for (int k = 0; k < 301; k++)             // saturate the drop counter
            send(k, 3, 1'b1, 1'b0, -1);
        send(8'hC0, WORDS, 1'b1, 1'b0, 27);
        idle();
        chk("drop_sat", 256'(drop_cnt), 256'(255));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/circ_frame_assembler.md
Name: circ_frame_assembler

Overview:
- Collects the serial corrected-symbol stream from the C1 decoder into one parallel 28-word frame.
- Presents the frame on a held-stable output bus, together with a one-cycle frame strobe, to the CIRC stagger-delay stage that follows it.
- The stagger delay and all later frame-rate stages advance only on FRAME_STB.
- Double-buffered: collection of frame N+1 overlaps presentation of frame N.

Parameters:
- WIDTH, 8, bits per symbol.
- WORDS, 28, symbols per frame; the frame index counter is $clog2(WORDS) bits wide.
- CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- CLK  in  1  system clock; every register is clocked on the rising edge.
- RST  in  1  synchronous active-high reset.
- IN_DATA  in  WIDTH  symbol from the C1 decoder.
- IN_VALID  in  1  IN_DATA is valid this cycle.
- IN_SOF  in  1  qualifies IN_VALID; marks symbol 0 of a frame.
- IN_RDY  out  1  block accepts a symbol this cycle.
- Q  out  [WORDS][WIDTH]  assembled frame; word i = i-th symbol received.
- FRAME_STB  out  1  one-cycle pulse when Q takes a new frame.
- FRAME_ERR  out  1  one-cycle pulse when a partial frame is discarded.
- DROP_CNT  out  CNT_W  saturating count of discarded partial frames.

Behaviour:
- Reset (RST=1 at a clock edge) sets:
  - Q = 0, FRAME_STB = 0, FRAME_ERR = 0, DROP_CNT = 0, IN_RDY = 0;
  - shadow buffer = 0, index = 0, state = HUNT.
- IN_RDY = 1 in every cycle that follows a non-reset cycle. The shadow buffer plus Q form a full double buffer, so the block never stalls. A symbol is accepted when IN_VALID && IN_RDY.
- Reset mid-frame discards the partial frame silently: no FRAME_ERR pulse, no DROP_CNT increment.
- FSM states: HUNT, FILL.
- HUNT:
  - accepted symbol with IN_SOF=1: write shadow[0], index <= 1, go to FILL;
  - accepted symbol with IN_SOF=0: dropped, no count.
- FILL:
  - accepted symbol with IN_SOF=0: write shadow[index], index++;
  - accepted symbol with IN_SOF=1 while index != 0: pulse FRAME_ERR, DROP_CNT++ (saturating at all-ones), then treat the symbol as a new symbol 0 (shadow[0], index <= 1, stay in FILL).
- Frame completion (accepted symbol with index == WORDS-1 and IN_SOF=0):
  - the same edge writes the final symbol into Q directly, and copies shadow[0..WORDS-2] into Q;
  - FRAME_STB pulses in the next cycle, so Q and FRAME_STB are both valid from the cycle after the last symbol;
  - index <= 0 and state stays FILL; the next frame must begin with IN_SOF=1.
- In FILL with index == 0, an accepted symbol with IN_SOF=0 is a sync loss:
  - pulse FRAME_ERR, no DROP_CNT increment;
  - drop the symbol and go to HUNT.
- Latency: last symbol accepted at edge t -> Q updated and FRAME_STB=1 at t+1.
- Q holds its value between strobes; partial fills never disturb Q.
- FRAME_STB and FRAME_ERR are never both asserted by the same symbol.

Optional Feature:
- Macro: CIRC_ERASURE_EN.
- Defined:
  - adds input IN_ERASE (1 bit, per symbol, sampled with IN_DATA);
  - adds output ERASE_Q [WORDS], assembled and shadowed exactly like Q, and used by downstream C2 erasure decoding;
  - adds output ERASE_ANY, registered with FRAME_STB, equal to the OR of ERASE_Q for the new frame;
  - all added outputs reset to 0.
- Undefined: no erasure ports or storage.

Decomposition:
- Package circ_pkg holds:
  - CIRC_WIDTH = 8, CIRC_C2_WORDS = 28;
  - typedef circ_sym_t (logic [7:0]);
  - typedef circ_frame_t (circ_sym_t [27:0]);
  - enum asm_state_t {HUNT, FILL}.
- No sub-module; a single module is natural.

Test Plan:
1. Reset, then 28 symbols 0x00..0x1B with SOF on the first, back-to-back valid -> one cycle after the last symbol, FRAME_STB=1 and Q[i]=i; FRAME_ERR stays 0.
2. Two frames back-to-back with zero gap: frame B symbols = 0x80+i -> Q holds frame A values until the cycle after B's last symbol, then Q[i]=0x80+i; exactly two FRAME_STB pulses.
3. SOF at symbol 10 of a frame, then 28 symbols 0x40+i -> FRAME_ERR pulse, DROP_CNT=1, Q=0x40+i after completion; Q unchanged before that.
4. 300 consecutive SOF-interrupted frames with CNT_W=8 -> DROP_CNT saturates at 255.
5. Symbols without SOF after reset, then a valid frame; plus a non-SOF symbol right after a completed frame -> pre-SOF symbols ignored; sync loss gives one FRAME_ERR, return to HUNT, next SOF frame assembles correctly.
6. RST asserted at symbol 15 -> the following cycle shows Q=0, IN_RDY=0, state HUNT, no FRAME_ERR pulse; with CIRC_ERASURE_EN defined, IN_ERASE on symbol 5 -> ERASE_Q[5]=1 and ERASE_ANY=1 with FRAME_STB.
